// File: rtl/fetch_unit.sv
// Instruction fetch stage: program counter, request/acknowledge instruction-memory read,
// 2-entry instruction buffer with valid/ready output, and redirect handling with stale-read drop.
`timescale 1ns/1ps
module fetch_unit #(
    parameter int INSTR_W = 16,
    parameter int PC_W    = 8,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [1:0]         out_opcode,
    output logic [PC_W-1:0]    out_pc
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    state_t               state_r;
    logic [PC_W-1:0]      pc_r;
    logic [PC_W-1:0]      drop_addr_r;
    logic [1:0]           count_r;
    logic [INSTR_W-1:0]   head_instr_r;
    logic [PC_W-1:0]      head_pc_r;
    logic [INSTR_W-1:0]   tail_instr_r;
    logic [PC_W-1:0]      tail_pc_r;
    logic                 push_s;
    logic                 pop_s;

    // The request depends only on registered state, so it cannot be withdrawn before its ack
    // (count only rises on an ack, and DROP only leaves on an ack).
    assign imem_req   = ((state_r == S_FETCH) && (count_r != 2'd2)) || (state_r == S_DROP);
    assign imem_addr  = (state_r == S_DROP) ? drop_addr_r : pc_r;
    assign out_valid  = (count_r != 2'd0);
    assign out_instr  = head_instr_r;
    assign out_pc     = head_pc_r;
    assign out_opcode = head_instr_r[INSTR_W-1 -: 2];

    assign push_s = (state_r == S_FETCH) && imem_req && imem_ack && !redirect;
    assign pop_s  = out_valid && out_ready;

    // Fetch sequencing: state, pc and the address held for a stale in-flight read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= S_IDLE;
            pc_r        <= RESET_PC;
            drop_addr_r <= {PC_W{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    state_r <= S_FETCH;
                    if (redirect) begin
                        pc_r <= redirect_pc;
                    end
                end
                S_FETCH: begin
                    if (redirect) begin
                        pc_r        <= redirect_pc;
                        drop_addr_r <= pc_r;
                        state_r     <= (imem_req && !imem_ack) ? S_DROP : S_FETCH;
                    end else if (imem_req && imem_ack) begin
                        pc_r <= pc_r + PC_W'(1);
                    end
                end
                S_DROP: begin
                    if (redirect) begin
                        pc_r <= redirect_pc;
                    end
                    if (imem_ack) begin
                        state_r <= S_FETCH;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    // Two-entry shift buffer; unused slots are kept at zero so an empty head reads 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r      <= 2'd0;
            head_instr_r <= {INSTR_W{1'b0}};
            head_pc_r    <= {PC_W{1'b0}};
            tail_instr_r <= {INSTR_W{1'b0}};
            tail_pc_r    <= {PC_W{1'b0}};
        end else if (redirect) begin
            count_r      <= 2'd0;
            head_instr_r <= {INSTR_W{1'b0}};
            head_pc_r    <= {PC_W{1'b0}};
            tail_instr_r <= {INSTR_W{1'b0}};
            tail_pc_r    <= {PC_W{1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        head_instr_r <= imem_rdata;
                        head_pc_r    <= pc_r;
                    end else begin
                        tail_instr_r <= imem_rdata;
                        tail_pc_r    <= pc_r;
                    end
                    count_r <= count_r + 2'd1;
                end
                2'b01: begin
                    head_instr_r <= tail_instr_r;
                    head_pc_r    <= tail_pc_r;
                    tail_instr_r <= {INSTR_W{1'b0}};
                    tail_pc_r    <= {PC_W{1'b0}};
                    count_r      <= count_r - 2'd1;
                end
                2'b11: begin
                    if (count_r == 2'd1) begin
                        head_instr_r <= imem_rdata;
                        head_pc_r    <= pc_r;
                    end else begin
                        head_instr_r <= tail_instr_r;
                        head_pc_r    <= tail_pc_r;
                        tail_instr_r <= imem_rdata;
                        tail_pc_r    <= pc_r;
                    end
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run, checked against a
// program-order reference (delivered pcs run consecutively from the reset or redirect target).
`timescale 1ns/1ps
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic [1:0]  out_opcode;
    logic [7:0]  out_pc;

    logic        req2;
    logic [7:0]  addr2;
    logic [15:0] rdata2;
    logic        v2;
    logic [15:0] instr2;
    logic [1:0]  op2;
    logic [7:0]  pc2;

    int          checks = 0;
    int          errors = 0;
    int          fixed_lat = 0;
    bit          rand_lat = 1'b0;
    bit          mix = 1'b0;
    int          wait_cnt;
    int          cur_lat;

    logic [7:0]  exp_next = 8'h00;
    int          xfers = 0;
    bit          have_prev = 1'b0;
    logic        p_req, p_ack, p_valid, p_ready, p_redirect;
    logic [7:0]  p_addr, p_pc;
    logic [15:0] p_instr;

    fetch_unit #(.INSTR_W(16), .PC_W(8), .RESET_PC(8'h00)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_opcode(out_opcode), .out_pc(out_pc)
    );

    fetch_unit #(.INSTR_W(16), .PC_W(8), .RESET_PC(8'hFE)) dut2 (
        .clk(clk), .reset(reset),
        .imem_req(req2), .imem_addr(addr2), .imem_ack(req2), .imem_rdata(rdata2),
        .redirect(1'b0), .redirect_pc(8'h00),
        .out_valid(v2), .out_ready(1'b1), .out_instr(instr2),
        .out_opcode(op2), .out_pc(pc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [7:0] a);
        if (mix) return {a[1:0], a[7:2], a};
        else return 16'h4000 + {8'h00, a};
    endfunction

    always_comb begin
        imem_rdata = mem_word(imem_addr);
        rdata2 = 16'h4000 + {8'h00, addr2};
    end

    // Memory with a per-request wait of cur_lat cycles; tolerates abandoned requests on reset.
    assign imem_ack = imem_req && (wait_cnt == cur_lat);
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= 0;
            cur_lat  <= fixed_lat;
        end else if (imem_req && imem_ack) begin
            wait_cnt <= 0;
            cur_lat  <= rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
        end else if (imem_req) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
            cur_lat  <= rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: mid-cycle scoreboard/protocol checks, then advance to just after the edge.
    task automatic tick();
        logic [15:0] w;
        @(negedge clk);
        if (reset) begin
            exp_next  = 8'h00;
            have_prev = 1'b0;
        end else begin
            if (have_prev && p_req && !p_ack) begin
                chk("req_hold", 32'(imem_req), 32'd1);
                chk("addr_hold", 32'(imem_addr), 32'(p_addr));
            end
            if (have_prev && p_valid && !p_ready && !p_redirect) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_pc", 32'(out_pc), 32'(p_pc));
                chk("stall_instr", 32'(out_instr), 32'(p_instr));
            end
            if (out_valid && out_ready) begin
                w = mem_word(exp_next);
                chk("xfer_pc", 32'(out_pc), 32'(exp_next));
                chk("xfer_instr", 32'(out_instr), 32'(w));
                chk("xfer_opcode", 32'(out_opcode), 32'(w[15:14]));
                exp_next = exp_next + 8'h01;
                xfers++;
            end
            if (redirect) exp_next = redirect_pc;
            p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr;
            p_valid = out_valid; p_ready = out_ready; p_redirect = redirect;
            p_pc = out_pc; p_instr = out_instr;
            have_prev = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_valid(input int max_cycles);
        int n;
        n = 0;
        while (!out_valid && n < max_cycles) begin
            tick();
            n++;
        end
        chk("wait_valid", 32'(out_valid), 32'd1);
    endtask

    initial begin
        int x0;
        logic [7:0] e2;
        reset = 1'b1;
        out_ready = 1'b1;
        redirect = 1'b0;
        redirect_pc = 8'h00;

        // Reset values and zero-wait streaming, including the RESET_PC=0xFE wrap instance.
        tick();
        tick();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_pc", 32'(out_pc), 32'd0);
        chk("rst_instr", 32'(out_instr), 32'd0);
        chk("rst_opcode", 32'(out_opcode), 32'd0);
        chk("rst_valid2", 32'(v2), 32'd0);
        reset = 1'b0;
        chk("idle_req", 32'(imem_req), 32'd0);
        tick();
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", 32'(imem_addr), 32'd0);
        chk("first_valid", 32'(out_valid), 32'd0);
        tick();
        for (int k = 0; k < 4; k++) begin
            e2 = 8'hFE + 8'(k);
            chk("stream_valid", 32'(out_valid), 32'd1);
            chk("stream_pc", 32'(out_pc), 32'(k));
            chk("stream_opcode", 32'(out_opcode), 32'd1);
            chk("wrap_valid", 32'(v2), 32'd1);
            chk("wrap_pc", 32'(pc2), 32'(e2));
            tick();
        end

        // Back-pressure: buffer fills to two and the request stops.
        out_ready = 1'b0;
        do_reset();
        repeat (6) tick();
        chk("full_valid", 32'(out_valid), 32'd1);
        chk("full_pc", 32'(out_pc), 32'd0);
        chk("full_req", 32'(imem_req), 32'd0);
        out_ready = 1'b1;
        tick();
        chk("drain_pc1", 32'(out_pc), 32'd1);
        tick();
        chk("drain_pc2", 32'(out_pc), 32'd2);

        // Redirect while a slow read is pending: stale read is dropped.
        fixed_lat = 3;
        do_reset();
        tick();
        chk("slow_req", 32'(imem_req), 32'd1);
        chk("slow_addr", 32'(imem_addr), 32'd0);
        tick();
        chk("slow_noack", 32'(imem_ack), 32'd0);
        redirect = 1'b1;
        redirect_pc = 8'h40;
        tick();
        redirect = 1'b0;
        chk("drop_req", 32'(imem_req), 32'd1);
        chk("drop_addr", 32'(imem_addr), 32'd0);
        chk("drop_valid", 32'(out_valid), 32'd0);
        tick();
        chk("drop_addr_ack", 32'(imem_addr), 32'd0);
        chk("drop_ack", 32'(imem_ack), 32'd1);
        tick();
        chk("post_drop_addr", 32'(imem_addr), 32'h40);
        wait_valid(12);
        chk("post_drop_pc", 32'(out_pc), 32'h40);
        chk("post_drop_instr", 32'(out_instr), 32'h4040);

        // Redirect together with an ack and a pop.
        fixed_lat = 0;
        do_reset();
        tick();
        tick();
        chk("rp_pc", 32'(out_pc), 32'd0);
        chk("rp_ack", 32'(imem_ack), 32'd1);
        x0 = xfers;
        redirect = 1'b1;
        redirect_pc = 8'h10;
        tick();
        redirect = 1'b0;
        chk("rp_pop_counted", 32'(xfers), 32'(x0 + 1));
        chk("rp_flushed", 32'(out_valid), 32'd0);
        chk("rp_addr", 32'(imem_addr), 32'h10);
        tick();
        chk("rp_new_pc", 32'(out_pc), 32'h10);
        repeat (4) tick();

        // Asynchronous reset with an entry buffered and a read pending.
        fixed_lat = 3;
        out_ready = 1'b0;
        do_reset();
        repeat (6) tick();
        chk("mid_valid", 32'(out_valid), 32'd1);
        chk("mid_req", 32'(imem_req), 32'd1);
        chk("mid_noack", 32'(imem_ack), 32'd0);
        reset = 1'b1;
        #1;
        chk("async_req", 32'(imem_req), 32'd0);
        chk("async_valid", 32'(out_valid), 32'd0);
        chk("async_pc", 32'(out_pc), 32'd0);
        fixed_lat = 0;
        out_ready = 1'b1;
        tick();
        reset = 1'b0;
        wait_valid(4);
        chk("restart_pc", 32'(out_pc), 32'd0);

        // Randomized traffic: latency, back-pressure, redirects.
        mix = 1'b1;
        rand_lat = 1'b1;
        do_reset();
        x0 = xfers;
        for (int i = 0; i < 600; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            redirect = ($urandom_range(0, 15) == 0);
            redirect_pc = 8'($urandom);
            tick();
        end
        redirect = 1'b0;
        chk("rand_progress", 32'(xfers > x0 + 60), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
